// File: rtl/disp_dispatch3_if.sv
// Producer-side handshake into the display dispatcher: valid/ready plus a tagged word.
interface disp_dispatch3_if #(
   parameter int unsigned DW = 12
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    in_dest;

   modport master (output in_valid, output in_data, output in_dest, input in_ready);
   modport slave  (input in_valid, input in_data, input in_dest, output in_ready);
endinterface

// File: rtl/disp_dispatch3.sv
// Producer side of the 3-channel one-hot display-data mux: buffers tagged words
// and presents each one on its channel for DWELL cycles, with a 1-cycle all-low gap.
module disp_dispatch3 #(
   parameter int unsigned DW    = 12,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DWELL = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   disp_dispatch3_if.slave bus,
   input  logic           flush,
   output logic           en1,
   output logic           en2,
   output logic           en3,
   output logic [DW-1:0]  data1,
   output logic [DW-1:0]  data2,
   output logic [DW-1:0]  data3,
   output logic           busy,
   output logic [7:0]     drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]    dest;
      logic [DW-1:0] data;
   } entry_t;

   entry_t               mem [DEPTH];
   entry_t               head;
   logic [PW-1:0]        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic                 full, empty, push, drop, load;
   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [2:0]           en_q, en_n;
   logic [2:0][DW-1:0]   dat_q, dat_n;
   logic                 busy_n;

   // FIFO status from registered pointers; extra MSB distinguishes full from empty
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   assign bus.in_ready = !full && !flush;
   assign push = bus.in_valid && bus.in_ready && (bus.in_dest != 2'd3);
   assign drop = bus.in_valid && bus.in_ready && (bus.in_dest == 2'd3);

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= '{dest: bus.in_dest, data: bus.in_data};
      end
   end

   // Next-state and next-output logic for the presentation FSM and FIFO pointers
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      en_n    = en_q;
      dat_n   = dat_q;
      load    = 1'b0;
      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
         en_n    = '0;
      end else begin
         case (state)
            IDLE, GAP: begin
               en_n = '0;
               if (!empty) begin
                  load    = 1'b1;
                  state_n = PRESENT;
                  cnt_n   = CW'(DWELL - 1);
                  case (head.dest)
                     2'd0:    begin en_n = 3'b001; dat_n[0] = head.data; end
                     2'd1:    begin en_n = 3'b010; dat_n[1] = head.data; end
                     default: begin en_n = 3'b100; dat_n[2] = head.data; end
                  endcase
               end else begin
                  state_n = IDLE;
               end
            end
            PRESENT: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CW'(1);
               end else begin
                  en_n    = '0;
                  state_n = GAP;
               end
            end
            default: begin
               state_n = IDLE;
               en_n    = '0;
            end
         endcase
      end
      wr_ptr_n = flush ? '0 : (push ? wr_ptr + PW'(1) : wr_ptr);
      rd_ptr_n = flush ? '0 : (load ? rd_ptr + PW'(1) : rd_ptr);
      busy_n   = (state_n != IDLE) || (wr_ptr_n != rd_ptr_n);
   end

   // State, pointer and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         en_q   <= '0;
         dat_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         en_q   <= en_n;
         dat_q  <= dat_n;
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         busy   <= busy_n;
      end
   end

   // Saturating count of words discarded for the invalid destination
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'd0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign en1   = en_q[0];
   assign en2   = en_q[1];
   assign en3   = en_q[2];
   assign data1 = dat_q[0];
   assign data2 = dat_q[1];
   assign data3 = dat_q[2];

endmodule

// File: tb/tb_disp_dispatch3.sv
// Bench for disp_dispatch3: directed steps plus random traffic against a
// timeline-based reference model (word queue + start-edge arithmetic).
module tb_disp_dispatch3;

   localparam int DW    = 12;
   localparam int DEPTH = 4;
   localparam int DWELL = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          en1, en2, en3;
   logic [DW-1:0] data1, data2, data3;
   logic          busy;
   logic [7:0]    drop_cnt;

   disp_dispatch3_if #(.DW(DW)) bus ();

   disp_dispatch3 #(.DW(DW), .DEPTH(DEPTH), .DWELL(DWELL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .flush    (flush),
      .en1      (en1),
      .en2      (en2),
      .en3      (en3),
      .data1    (data1),
      .data2    (data2),
      .data3    (data3),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: pending words, edge count, start edge of the word on display
   logic [13:0]   mq[$];
   int            k;
   int            last_start;
   int            next_load;
   logic [1:0]    cur_dest;
   logic [DW-1:0] m_data [3];
   int            m_drop;

   int vectors;
   int miscompares;

   function automatic logic [2:0] exp_en();
      if (k >= last_start && (k - last_start) < DWELL) return 3'(3'b001 << cur_dest);
      return 3'b000;
   endfunction

   function automatic logic exp_busy();
      return (k >= last_start && (k - last_start) <= DWELL) || (mq.size() > 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      last_start = -1000;
      next_load  = 0;
      cur_dest   = 2'd0;
      for (int i = 0; i < 3; i++) m_data[i] = '0;
      m_drop = 0;
   endtask

   task automatic check_outputs();
      chk("en",       32'({en3, en2, en1}), 32'(exp_en()));
      chk("data1",    32'(data1), 32'(m_data[0]));
      chk("data2",    32'(data2), 32'(m_data[1]));
      chk("data3",    32'(data3), 32'(m_data[2]));
      chk("busy",     32'(busy), 32'(exp_busy()));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("onehot",   32'($countones({en3, en2, en1}) <= 1), 32'(1));
   endtask

   // One clock cycle: drive inputs, check ready, advance model at the edge, check outputs
   task automatic step(input logic v, input logic [1:0] d, input logic [DW-1:0] x,
                       input logic f, output logic acc);
      logic        rdy;
      logic [13:0] w;
      bus.in_valid = v;
      bus.in_dest  = d;
      bus.in_data  = x;
      flush        = f;
      rdy = (mq.size() < DEPTH) && !f;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      @(posedge clk);
      k++;
      if (f) begin
         mq.delete();
         last_start = -1000;
         next_load  = k + 1;
      end else begin
         if (mq.size() > 0 && k >= next_load) begin
            w = mq.pop_front();
            last_start = k;
            next_load  = k + DWELL + 1;
            cur_dest   = w[13:12];
            m_data[w[13:12]] = w[11:0];
         end
         if (v && rdy) begin
            if (d != 2'd3) mq.push_back({d, x});
            else if (m_drop < 255) m_drop++;
         end
      end
      acc = v && rdy;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0, acc);
   endtask

   task automatic push(input logic [1:0] d, input logic [DW-1:0] x);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 40) begin
         step(1'b1, d, x, 1'b0, acc);
         tries++;
      end
      if (!acc) begin
         vectors++;
         miscompares++;
         $error("FAIL push_timeout observed=%0d tries expected=accept", tries);
      end
   endtask

   // Async reset without a clock edge, then release on the falling edge
   task automatic do_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      #1;
      model_reset();
      chk("rst_en",    32'({en3, en2, en1}), 32'(0));
      chk("rst_data1", 32'(data1), 32'(0));
      chk("rst_data2", 32'(data2), 32'(0));
      chk("rst_data3", 32'(data3), 32'(0));
      chk("rst_drop",  32'(drop_cnt), 32'(0));
      chk("rst_busy",  32'(busy), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(bus.in_ready), 32'(1));
   endtask

   initial begin
      logic          acc;
      logic          v, f;
      logic [1:0]    d;
      vectors      = 0;
      miscompares  = 0;
      k            = 0;
      rst_n        = 1'b1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_dest  = 2'd0;
      bus.in_data  = '0;
      model_reset();
      #2;
      do_reset();
      idle(2);

      // Single word to channel 2
      step(1'b1, 2'd1, 12'hABC, 1'b0, acc);
      chk("t2_en_T", 32'({en3, en2, en1}), 32'(0));
      idle(1);
      chk("t2_en2_T1", 32'({en3, en2, en1}), 32'(3'b010));
      chk("t2_data2_T1", 32'(data2), 32'(12'hABC));
      idle(3);
      chk("t2_en2_T4", 32'({en3, en2, en1}), 32'(3'b010));
      idle(1);
      chk("t2_en_T5", 32'({en3, en2, en1}), 32'(0));
      chk("t2_data2_T5", 32'(data2), 32'(12'hABC));
      idle(4);

      // Back-pressure: five words back-to-back
      push(2'd0, 12'd1);
      push(2'd1, 12'd2);
      push(2'd2, 12'd3);
      push(2'd0, 12'd4);
      push(2'd1, 12'd5);
      idle(30);

      // Invalid destination, then saturation
      for (int i = 0; i < 3; i++) push(2'd3, 12'($urandom));
      idle(1);
      chk("t4_drop3", 32'(drop_cnt), 32'(3));
      for (int i = 0; i < 300; i++) push(2'd3, 12'($urandom));
      idle(1);
      chk("t4_drop255", 32'(drop_cnt), 32'(255));

      // Flush in the second PRESENT cycle with two queued and a push offered
      push(2'd0, 12'h001);
      push(2'd1, 12'h002);
      push(2'd2, 12'h003);
      step(1'b1, 2'd1, 12'h777, 1'b1, acc);
      chk("t5_en", 32'({en3, en2, en1}), 32'(0));
      chk("t5_busy", 32'(busy), 32'(0));
      chk("t5_data1", 32'(data1), 32'(12'h001));
      idle(3);
      chk("t5_busy_after", 32'(busy), 32'(0));
      chk("t5_en_after", 32'({en3, en2, en1}), 32'(0));
      idle(2);

      // Same-channel repeat
      step(1'b1, 2'd2, 12'h111, 1'b0, acc);
      step(1'b1, 2'd2, 12'h222, 1'b0, acc);
      chk("t6_en3_first", 32'({en3, en2, en1}), 32'(3'b100));
      chk("t6_data3_first", 32'(data3), 32'(12'h111));
      idle(4);
      chk("t6_gap", 32'({en3, en2, en1}), 32'(0));
      chk("t6_data3_gap", 32'(data3), 32'(12'h111));
      idle(1);
      chk("t6_en3_second", 32'({en3, en2, en1}), 32'(3'b100));
      chk("t6_data3_second", 32'(data3), 32'(12'h222));
      idle(6);

      // Async reset in the middle of a dwell
      push(2'd1, 12'h5A5);
      idle(2);
      do_reset();
      idle(2);

      // Random traffic with occasional flush and drain windows
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 9) < 6);
         if ((i % 100) > 85) v = 1'b0;
         d = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         f = ($urandom_range(0, 49) == 0);
         step(v, d, 12'($urandom), f, acc);
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
